// File: rtl/unpack_pkg.sv
// rtl/unpack_pkg.sv - shared types and width helpers for the unpack family
package unpack_pkg;

    // Element emission order selected by MSB_FIRST.
    typedef enum logic {
        ORDER_LSB = 1'b0,
        ORDER_MSB = 1'b1
    } order_e;

    // Width needed to hold an element count of 0..d.
    function automatic int count_width(input int d);
        return $clog2(d + 1);
    endfunction

    // Width of an element index 0..d-1, never narrower than one bit.
    function automatic int index_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/unpack_select.sv
// rtl/unpack_select.sv - combinational D:1 element mux over a packed beat
//
// Ports:
//   data : packed beat, element i at bits [i*W +: W]
//   sel  : element index, expected in 0..D-1
//   elem : selected element (zero if sel is out of range)
module unpack_select #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int IW = 2
) (
    input  logic [D*W-1:0] data,
    input  logic [IW-1:0]  sel,
    output logic [W-1:0]   elem
);

    always_comb begin
        elem = '0;
        for (int i = 0; i < D; i++) begin
            if (sel == IW'(i)) begin
                elem = data[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/unpack_stream.sv
// rtl/unpack_stream.sv - splits packed beats of D W-bit words into a word stream
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   s_data          : packed beat, element i at bits [i*W +: W]
//   s_count         : valid elements in the beat (clamped to D)
//   s_valid/s_ready : beat handshake
//   m_data          : current element
//   m_last          : final element of the beat
//   m_valid/m_ready : element handshake
module unpack_stream
    import unpack_pkg::*;
#(
    parameter int W         = 8,
    parameter int D         = 4,
    parameter int MSB_FIRST = 0,
    parameter int C         = count_width(D)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [D*W-1:0] s_data,
    input  logic [C-1:0]   s_count,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [W-1:0]   m_data,
    output logic           m_last,
    output logic           m_valid,
    input  logic           m_ready
);

    localparam int             IW      = index_width(D);
    localparam order_e         ORD     = (MSB_FIRST != 0) ? ORDER_MSB : ORDER_LSB;
    localparam logic [C-1:0]   D_C     = C'(D);
    localparam logic [IW-1:0]  IDX_TOP = IW'(D - 1);

    logic [D*W-1:0] hold;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  end_idx;

    logic [C-1:0]   n_eff;
    logic           accept;
    logic [IW-1:0]  first_idx;
    logic [IW-1:0]  stop_idx;
    logic [IW-1:0]  idx_nxt;
    logic [IW-1:0]  sel;
    logic [D*W-1:0] src;
    logic [W-1:0]   elem;

    // A new beat may enter when idle, or in the same cycle the last element
    // leaves, which gives back-to-back beats without a bubble.
    assign s_ready = !rst && (!m_valid || (m_last && m_ready));
    assign accept  = s_valid && s_ready;

    always_comb begin
        n_eff = (s_count > D_C) ? D_C : s_count;
        if (ORD == ORDER_MSB) begin
            first_idx = IDX_TOP;
            stop_idx  = IW'(D - int'(n_eff));
            idx_nxt   = idx - IW'(1);
        end else begin
            first_idx = '0;
            stop_idx  = IW'(int'(n_eff) - 1);
            idx_nxt   = idx + IW'(1);
        end
        // On accept the first element comes straight from the input beat,
        // otherwise the next element comes from the hold register. idx_nxt
        // is only consumed while m_last is low, so it stays inside 0..D-1.
        src = accept ? s_data : hold;
        sel = accept ? first_idx : idx_nxt;
    end

    unpack_select #(
        .W  (W),
        .D  (D),
        .IW (IW)
    ) u_select (
        .data (src),
        .sel  (sel),
        .elem (elem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hold    <= '0;
            idx     <= '0;
            end_idx <= '0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (accept) begin
            hold <= s_data;
            if (n_eff != '0) begin
                m_valid <= 1'b1;
                m_data  <= elem;
                m_last  <= (n_eff == C'(1));
                idx     <= first_idx;
                end_idx <= stop_idx;
            end else begin
                // Empty beat: swallowed, and any finished beat leaves EMIT.
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end else if (m_valid && m_ready) begin
            if (m_last) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end else begin
                idx    <= idx_nxt;
                m_data <= elem;
                m_last <= (idx_nxt == end_idx);
            end
        end
    end

endmodule

// File: tb/tb_unpack_stream.sv
// tb/tb_unpack_stream.sv - self-checking bench for unpack_stream
module tb_unpack_stream;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       l;
    } obs_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // unit 0: MSB_FIRST=0, unit 1: MSB_FIRST=1
    logic [31:0] s_data_l = '0, s_data_m = '0;
    logic [2:0]  s_count_l = '0, s_count_m = '0;
    logic        s_valid_l = 1'b0, s_valid_m = 1'b0;
    logic        m_ready_l = 1'b1, m_ready_m = 1'b1;
    logic        s_ready_l, s_ready_m;
    logic [7:0]  m_data_l, m_data_m;
    logic        m_last_l, m_last_m;
    logic        m_valid_l, m_valid_m;

    unpack_stream #(.W(8), .D(4), .MSB_FIRST(0)) dut_lsb (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data_l),
        .s_count (s_count_l),
        .s_valid (s_valid_l),
        .s_ready (s_ready_l),
        .m_data  (m_data_l),
        .m_last  (m_last_l),
        .m_valid (m_valid_l),
        .m_ready (m_ready_l)
    );

    unpack_stream #(.W(8), .D(4), .MSB_FIRST(1)) dut_msb (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data_m),
        .s_count (s_count_m),
        .s_valid (s_valid_m),
        .s_ready (s_ready_m),
        .m_data  (m_data_m),
        .m_last  (m_last_m),
        .m_valid (m_valid_m),
        .m_ready (m_ready_m)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    obs_t obs_q[2][$];
    exp_t exp_q[2][$];
    logic rnd[2] = '{1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: record consumed elements, check s_ready rule and stall stability.
    logic       stall_l = 1'b0, prst_l = 1'b1, pl_l = 1'b0;
    logic [7:0] pd_l = '0;
    always @(negedge clk) begin
        if (!rst && m_valid_l && m_ready_l) obs_q[0].push_back('{cyc, m_data_l, m_last_l});
        if (!rst) chk("s_ready_rule_lsb", s_ready_l, !m_valid_l || (m_last_l && m_ready_l));
        if (stall_l && !rst && !prst_l) begin
            chk("stall_valid_lsb", m_valid_l, 1);
            chk("stall_data_lsb", m_data_l, pd_l);
            chk("stall_last_lsb", m_last_l, pl_l);
        end
        stall_l = m_valid_l && !m_ready_l;
        pd_l    = m_data_l;
        pl_l    = m_last_l;
        prst_l  = rst;
    end

    logic       stall_m = 1'b0, prst_m = 1'b1, pl_m = 1'b0;
    logic [7:0] pd_m = '0;
    always @(negedge clk) begin
        if (!rst && m_valid_m && m_ready_m) obs_q[1].push_back('{cyc, m_data_m, m_last_m});
        if (!rst) chk("s_ready_rule_msb", s_ready_m, !m_valid_m || (m_last_m && m_ready_m));
        if (stall_m && !rst && !prst_m) begin
            chk("stall_valid_msb", m_valid_m, 1);
            chk("stall_data_msb", m_data_m, pd_m);
            chk("stall_last_msb", m_last_m, pl_m);
        end
        stall_m = m_valid_m && !m_ready_m;
        pd_m    = m_data_m;
        pl_m    = m_last_m;
        prst_m  = rst;
    end

    // Random back-pressure generators.
    always @(posedge clk) if (rnd[0]) begin #1; m_ready_l = 1'($urandom_range(0, 1)); end
    always @(posedge clk) if (rnd[1]) begin #1; m_ready_m = 1'($urandom_range(0, 1)); end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic rdy(input int u);
        return (u == 0) ? s_ready_l : s_ready_m;
    endfunction

    task automatic drive(input int u, input logic [31:0] d, input logic [2:0] c, input logic v);
        if (u == 0) begin
            s_data_l = d; s_count_l = c; s_valid_l = v;
        end else begin
            s_data_m = d; s_count_m = c; s_valid_m = v;
        end
    endtask

    // Reference: n = min(count, 4); LSB order emits 0..n-1, MSB order 3 down to 4-n.
    task automatic push_exp(input int u, input logic [31:0] d, input logic [2:0] c);
        int   n;
        int   e;
        n = (int'(c) > 4) ? 4 : int'(c);
        for (int k = 0; k < n; k++) begin
            e = (u == 0) ? k : 3 - k;
            exp_q[u].push_back('{d[e*8 +: 8], k == n - 1});
        end
    endtask

    // Called right after a posedge; returns right after the accepting posedge.
    task automatic send(input int u, input logic [31:0] d, input logic [2:0] c);
        logic ok;
        ok = 1'b0;
        drive(u, d, c, 1'b1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy(u)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        drive(u, d, c, 1'b0);
        if (ok) push_exp(u, d, c);
    endtask

    task automatic wait_drain(input int u);
        for (int i = 0; i < 600 && obs_q[u].size() < exp_q[u].size(); i++) @(negedge clk);
        chk("drain_count", obs_q[u].size(), exp_q[u].size());
        @(posedge clk);
        #1;
    endtask

    task automatic check_queue(input int u, input string tag, input logic consec);
        obs_t o;
        exp_t e;
        int   c0;
        int   k;
        k  = 0;
        c0 = (obs_q[u].size() > 0) ? obs_q[u][0].cyc : 0;
        while (exp_q[u].size() > 0) begin
            e = exp_q[u].pop_front();
            if (obs_q[u].size() == 0) begin
                chk({tag, "_missing"}, 0, 1);
            end else begin
                o = obs_q[u].pop_front();
                chk({tag, "_data"}, o.d, e.d);
                chk({tag, "_last"}, o.l, e.l);
                if (consec) chk({tag, "_cycle"}, o.cyc - c0, k);
            end
            k++;
        end
        chk({tag, "_extra"}, obs_q[u].size(), 0);
        obs_q[u].delete();
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  rc;

        // Reset values.
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid_l, 0);
        chk("rst_m_last", m_last_l, 0);
        chk("rst_m_data", m_data_l, 0);
        chk("rst_s_ready", s_ready_l, 0);
        chk("rst_m_valid_msb", m_valid_m, 0);
        chk("rst_s_ready_msb", s_ready_m, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full beat, LSB first, latency of one cycle.
        send(0, 32'h44332211, 3'd4);
        @(negedge clk);
        chk("latency_valid", m_valid_l, 1);
        chk("latency_data", m_data_l, 32'h11);
        chk("latency_last", m_last_l, 0);
        wait_drain(0);
        check_queue(0, "full_lsb", 1'b1);

        // MSB first, partial and clamped count.
        send(1, 32'h44332211, 3'd2);
        wait_drain(1);
        check_queue(1, "partial_msb", 1'b1);
        send(1, 32'h44332211, 3'd7);
        wait_drain(1);
        check_queue(1, "clamp_msb", 1'b1);

        // Zero-count beat is swallowed.
        send(0, 32'hDEADBEEF, 3'd0);
        @(negedge clk);
        chk("zero_no_output", m_valid_l, 0);
        @(posedge clk);
        #1;
        send(0, 32'h000000AA, 3'd1);
        wait_drain(0);
        check_queue(0, "single", 1'b0);

        // Back-to-back beats: eight elements in eight consecutive cycles.
        send(0, 32'h44332211, 3'd4);
        send(0, 32'h88776655, 3'd4);
        wait_drain(0);
        check_queue(0, "b2b", 1'b1);

        // Random beats with random back-pressure, both orders.
        for (int u = 0; u < 2; u++) begin
            rnd[u] = 1'b1;
            for (int b = 0; b < 8; b++) begin
                rd = $urandom;
                rc = 3'($urandom_range(0, 4));
                send(u, rd, rc);
            end
            wait_drain(u);
            rnd[u] = 1'b0;
            @(posedge clk);
            #1;
            if (u == 0) m_ready_l = 1'b1; else m_ready_m = 1'b1;
            check_queue(u, (u == 0) ? "rand_lsb" : "rand_msb", 1'b0);
        end

        // Reset in the middle of a beat.
        send(0, 32'h44332211, 3'd4);
        for (int i = 0; i < 50 && obs_q[0].size() < 2; i++) @(negedge clk);
        chk("pre_reset_elems", obs_q[0].size(), 2);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        m_ready_l = 1'b0;
        @(negedge clk);
        chk("mid_rst_s_ready", s_ready_l, 0);
        chk("mid_rst_s_ready_msb", s_ready_m, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_m_valid", m_valid_l, 0);
        chk("post_rst_m_last", m_last_l, 0);
        obs_q[0].delete();
        exp_q[0].delete();
        @(posedge clk);
        #1;
        m_ready_l = 1'b1;
        send(0, 32'h44332211, 3'd4);
        wait_drain(0);
        check_queue(0, "after_reset", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unpack_stream.md
Name: unpack_stream

Overview:
- Parametrised successor to the fixed-ratio unpacker: splits one packed beat of D words, each W bits, into a serial stream of single words.
- Adds:
  - a per-beat element count, so partial beats are allowed;
  - a selectable element order;
  - an end-of-beat marker on the output;
  - zero-bubble back-to-back beats.
- Sits between wide producers (memory, packed compute results) and narrow word-serial consumers in the datapath.

Parameters:
- W, 8, element width in bits.
- D, 4, elements per packed beat (D >= 1).
- MSB_FIRST, 0, element order: 0 emits index 0 first, 1 emits index D-1 first.
- C, $clog2(D+1), width of the count field (derived; do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- s_data  input  D*W  packed beat; element i occupies bits [i*W +: W].
- s_count  input  C  number of valid elements in the beat.
- s_valid  input  1  beat valid.
- s_ready  output  1  beat accepted when s_valid & s_ready at posedge.
- m_data  output  W  current element.
- m_last  output  1  high on the final element of a beat.
- m_valid  output  1  element valid.
- m_ready  input  1  element consumed when m_valid & m_ready at posedge.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values (registered at the first posedge with rst high):
  - m_valid=0, m_last=0, m_data=0;
  - internal count, index and held beat cleared.
- s_ready is forced to 0 while rst is high.
- State is implied by m_valid:
  - IDLE (m_valid=0): s_ready=1.
  - EMIT (m_valid=1): s_ready = m_last & m_ready, combinational. This is the only combinational path from m_ready to s_ready.
- Accept (s_valid & s_ready):
  - s_data is latched into the hold register.
  - Effective count n = min(s_count, D).
  - n=0: beat is discarded, no output, state unchanged (stays IDLE, or goes IDLE after the current last element is consumed).
  - n>0: next cycle m_valid=1 and m_data = first element; m_last=1 iff n=1.
- Latency: first element is valid on the cycle after accept.
- Element sequence:
  - MSB_FIRST=0: elements 0..n-1.
  - MSB_FIRST=1: elements D-1 down to D-n, i.e. the n highest-indexed elements.
- On m_valid & m_ready with m_last=0: advance to the next element; m_last rises with the final element.
- On m_valid & m_ready with m_last=1:
  - if a new beat is accepted in the same cycle, its first element is presented on the next cycle (no bubble; sustained throughput is one element per cycle);
  - otherwise m_valid drops to 0.
- Stall: while m_valid & !m_ready, m_data and m_last hold stable and s_ready=0.
- A held s_valid must not change s_data/s_count until accepted. The block relies on this and does not check it.
- Reset mid-beat: remaining elements are dropped; the output is idle after reset; no partial element is presented.
- Index counter width is $clog2(D), minimum 1. It must never index outside 0..D-1, including D=1 (every element is last).

Decomposition:
- Shared package unpack_pkg:
  - count_width(D) function;
  - order enum ORDER_LSB/ORDER_MSB for MSB_FIRST.
- One natural sub-module, unpack_select: a combinational W-wide D:1 element mux (hold register, index) -> element. It is reused by future pack/unpack variants.
- Control (count, index, last, handshake) stays in unpack_stream.

Test Plan:
- W=8, D=4, MSB_FIRST=0. Beat 0x44332211, count 4, m_ready=1. Required: m_data 0x11,0x22,0x33,0x44 on consecutive cycles; m_last only on 0x44; first output one cycle after accept.
- Same beat with MSB_FIRST=1, count 2. Required: 0x44 then 0x33 with m_last on 0x33; count 7 is clamped and yields 4 elements 0x44..0x11.
- Count 0 beat 0xDEADBEEF, then count 1 beat 0x000000AA. Required: only 0xAA is emitted, with m_last=1; the zero-count beat is consumed with no output.
- Back-to-back: two count-4 beats held valid, m_ready=1. Required: 8 elements in 8 consecutive cycles; s_ready high exactly on the cycles m_last & m_ready.
- Random m_ready stalls, 8 random beats, random counts 0..4. Required: output sequence matches a reference model; m_data/m_last stable during stall.
- Assert rst after 2 of 4 elements. Required: next cycle m_valid=0, s_ready=0 during rst; a new beat after reset emits from element 0.
